// File: rtl/btn_press_detector.sv
// Push-button conditioner: 2-FF synchronizer feeding a debounce FSM.
// Emits a debounced level plus press/release/long/repeat single-cycle pulses.
module btn_press_detector #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 12500000,
  parameter int REPEAT_CYCLES   = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  // state     | meaning
  // IDLE      | released and stable
  // DEB_PRESS | candidate press, counting stable high samples
  // HELD      | pressed, hold timer running toward long press
  // REPEAT    | long press reached, repeat timer running
  // DEB_REL   | candidate release, timers frozen, level still 1
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    DEB_REL   = 3'd4
  } state_t;

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  logic sync_1, btn_s;
  state_t state, state_nxt;
  logic [CW-1:0] deb_cnt, deb_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;
  logic [CW-1:0] rep_cnt, rep_nxt;
  logic ret_repeat, ret_repeat_nxt;
  logic pressed_nxt, press_nxt, release_nxt, long_nxt, repeat_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      btn_s  <= sync_1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      ret_repeat    <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_nxt;
      deb_cnt       <= deb_nxt;
      hold_cnt      <= hold_nxt;
      rep_cnt       <= rep_nxt;
      ret_repeat    <= ret_repeat_nxt;
      pressed       <= pressed_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    deb_nxt        = deb_cnt;
    hold_nxt       = hold_cnt;
    rep_nxt        = rep_cnt;
    ret_repeat_nxt = ret_repeat;
    pressed_nxt    = pressed;
    press_nxt      = 1'b0;
    release_nxt    = 1'b0;
    long_nxt       = 1'b0;
    repeat_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        deb_nxt = '0;
        if (btn_s) begin
          state_nxt = DEB_PRESS;
          deb_nxt   = CW'(1);
        end
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = HELD;
          pressed_nxt = 1'b1;
          press_nxt   = 1'b1;
          hold_nxt    = '0;
          deb_nxt     = '0;
        end else begin
          deb_nxt = deb_cnt + CW'(1);
        end
      end
      HELD: begin
        // a low sample takes priority so the hold timer never advances while releasing
        if (!btn_s) begin
          state_nxt      = DEB_REL;
          deb_nxt        = CW'(1);
          ret_repeat_nxt = 1'b0;
        end else if (hold_cnt == LONG_LAST) begin
          state_nxt = REPEAT;
          long_nxt  = 1'b1;
          rep_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + CW'(1);
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          state_nxt      = DEB_REL;
          deb_nxt        = CW'(1);
          ret_repeat_nxt = 1'b1;
        end else if (rep_cnt == REP_LAST) begin
          repeat_nxt = 1'b1;
          rep_nxt    = '0;
        end else begin
          rep_nxt = rep_cnt + CW'(1);
        end
      end
      DEB_REL: begin
        if (btn_s) begin
          state_nxt = ret_repeat ? REPEAT : HELD;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          pressed_nxt = 1'b0;
          release_nxt = 1'b1;
          deb_nxt     = '0;
        end else begin
          deb_nxt = deb_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        deb_nxt   = '0;
      end
    endcase
  end

endmodule
